// File: rtl/keystream_hash_gen_pkg.sv
// Shared types, constants and the reference mix round for the keystream hash generator.
package keystream_hash_gen_pkg;

  // Generator states, kept as plain constants so older tools and scripts can decode them.
  typedef logic [2:0] hash_generator_state_t;

  localparam hash_generator_state_t H_GROUND       = 3'd0;
  localparam hash_generator_state_t H_FIRST_QUERRY = 3'd1;
  localparam hash_generator_state_t H_READY        = 3'd2;
  localparam hash_generator_state_t H_QUERRIED     = 3'd3;
  localparam hash_generator_state_t H_PULSE_OUT    = 3'd4;
  localparam hash_generator_state_t H_EXHAUSTED    = 3'd5;

  // Golden-ratio constant added in every round.
  localparam logic [31:0] HASH_CONST = 32'h9E3779B9;

  // One mix round: rotl(h,5) ^ (h + HASH_CONST), modulo 2^32.
  function automatic logic [31:0] hash_mix_round(input logic [31:0] h);
    return {h[26:0], h[31:27]} ^ (h + HASH_CONST);
  endfunction

  // Round-0 value for a given key and block counter.
  function automatic logic [31:0] hash_seed(input logic [31:0] key, input logic [15:0] ctr);
    return key ^ {16'h0000, ctr};
  endfunction

endpackage

// File: rtl/keystream_hash_gen_mix_round.sv
// Combinational single mix round; the top iterates one copy over several clocks.
module keystream_hash_gen_mix_round
  import keystream_hash_gen_pkg::*;
(
  input  logic [31:0] h_i,
  output logic [31:0] h_o
);

  assign h_o = hash_mix_round(h_i);

endmodule

// File: rtl/keystream_hash_gen.sv
// Keystream source: hashes key and block counter into a 32-bit word, hands its bytes out
// LSB first on request, and regenerates with the next counter value once the word is used up.
module keystream_hash_gen
  import keystream_hash_gen_pkg::*;
#(
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned BUF_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] key_i,
  input  logic        key_load_i,
  input  logic        req_i,
  output logic        ready_o,
  output logic [7:0]  hash_byte_o,
  output logic        hash_valid_o,
  output logic [15:0] block_ctr_o
);

  localparam int unsigned RndW  = $clog2(ROUNDS + 1);
  localparam int unsigned MarkW = $clog2(BUF_BYTES);

  hash_generator_state_t state_q, state_d;
  logic [31:0]           key_q, key_d;
  logic [15:0]           ctr_q, ctr_d;
  logic [MarkW-1:0]      marker_q, marker_d;
  logic [RndW-1:0]       rnd_q, rnd_d;
  logic [31:0]           h_q, h_d;
  logic [31:0]           buf_q, buf_d;
  logic [7:0]            byte_q, byte_d;

  logic [31:0] h_mixed;
  logic [15:0] ctr_inc;
  logic        last_round;
  logic        last_byte;
  logic [7:0]  sel_byte;

  keystream_hash_gen_mix_round u_mix_round (
    .h_i (h_q),
    .h_o (h_mixed)
  );

  assign ctr_inc    = ctr_q + 16'd1;
  assign last_round = (rnd_q == RndW'(ROUNDS - 1));
  assign last_byte  = (marker_q == MarkW'(BUF_BYTES - 1));
  assign sel_byte   = buf_q[{marker_q, 3'b000} +: 8];

  assign ready_o      = (state_q == H_GROUND) || (state_q == H_READY);
  assign hash_valid_o = (state_q == H_PULSE_OUT);
  assign hash_byte_o  = byte_q;
  assign block_ctr_o  = ctr_q;

  // Next-state logic: key load overrides everything, otherwise walk the generator FSM.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    ctr_d    = ctr_q;
    marker_d = marker_q;
    rnd_d    = rnd_q;
    h_d      = h_q;
    buf_d    = buf_q;
    byte_d   = byte_q;

    if (key_load_i) begin
      key_d    = key_i;
      ctr_d    = '0;
      marker_d = '0;
      rnd_d    = '0;
      state_d  = H_GROUND;
    end else begin
      case (state_q)
        H_GROUND: begin
          if (req_i) begin
            ctr_d   = '0;
            h_d     = hash_seed(key_q, 16'h0000);
            rnd_d   = '0;
            state_d = H_FIRST_QUERRY;
          end
        end
        H_FIRST_QUERRY: begin
          h_d   = h_mixed;
          rnd_d = rnd_q + RndW'(1);
          // The first byte is latched straight from the final round to save a cycle.
          if (last_round) begin
            buf_d    = h_mixed;
            byte_d   = h_mixed[7:0];
            marker_d = '0;
            rnd_d    = '0;
            state_d  = H_PULSE_OUT;
          end
        end
        H_READY: begin
          if (req_i) begin
            state_d = H_QUERRIED;
          end
        end
        H_QUERRIED: begin
          byte_d  = sel_byte;
          state_d = H_PULSE_OUT;
        end
        H_PULSE_OUT: begin
          marker_d = marker_q + MarkW'(1);
          if (last_byte) begin
            // Counter advances as the regeneration starts; seed uses the new value.
            ctr_d   = ctr_inc;
            h_d     = hash_seed(key_q, ctr_inc);
            rnd_d   = '0;
            state_d = H_EXHAUSTED;
          end else begin
            state_d = H_READY;
          end
        end
        H_EXHAUSTED: begin
          h_d   = h_mixed;
          rnd_d = rnd_q + RndW'(1);
          if (last_round) begin
            buf_d    = h_mixed;
            marker_d = '0;
            rnd_d    = '0;
            state_d  = H_READY;
          end
        end
        default: begin
          state_d = H_GROUND;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= H_GROUND;
      key_q    <= '0;
      ctr_q    <= '0;
      marker_q <= '0;
      rnd_q    <= '0;
      h_q      <= '0;
      buf_q    <= '0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      ctr_q    <= ctr_d;
      marker_q <= marker_d;
      rnd_q    <= rnd_d;
      h_q      <= h_d;
      buf_q    <= buf_d;
      byte_q   <= byte_d;
    end
  end

endmodule

// File: tb/tb_keystream_hash_gen.sv
// Scoreboard bench: two generators (1 and 4 rounds); drivers queue expected bytes and
// arrival cycles, per-instance monitors pop and compare on every valid pulse.
module tb_keystream_hash_gen;

  localparam int unsigned R1 = 1;
  localparam int unsigned R4 = 4;

  localparam logic [31:0] K2 = 32'hA5A5_0F0F;
  localparam logic [31:0] K4 = 32'h0BAD_F00D;
  localparam logic [31:0] K5 = 32'h1357_9BDF;
  localparam logic [31:0] K6 = 32'hCAFE_1234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] key1, key4;
  logic        load1, load4, req1, req4;
  logic        ready1, ready4, valid1, valid4;
  logic [7:0]  byte1, byte4;
  logic [15:0] ctr1, ctr4;

  keystream_hash_gen #(.ROUNDS(R1), .BUF_BYTES(4)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .key_i        (key1),
    .key_load_i   (load1),
    .req_i        (req1),
    .ready_o      (ready1),
    .hash_byte_o  (byte1),
    .hash_valid_o (valid1),
    .block_ctr_o  (ctr1)
  );

  keystream_hash_gen #(.ROUNDS(R4), .BUF_BYTES(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .key_i        (key4),
    .key_load_i   (load4),
    .req_i        (req4),
    .ready_o      (ready4),
    .hash_byte_o  (byte4),
    .hash_valid_o (valid4),
    .block_ctr_o  (ctr4)
  );

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference of the mix.
  function automatic logic [31:0] tb_round(input logic [31:0] h);
    logic [31:0] r;
    r = (h << 5) | (h >> 27);
    return r ^ (h + 32'h9E3779B9);
  endfunction

  function automatic logic [7:0] wbyte(input logic [31:0] k, input logic [15:0] c,
                                       input int r, input int b);
    logic [31:0] h;
    h = k ^ {16'h0000, c};
    for (int i = 0; i < r; i++) h = tb_round(h);
    return h[8*b +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitors: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_extra_valid: got pulse at cycle %0d want none", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_byte", {24'h0, byte1}, {24'h0, e1.b});
        check("dut1_cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut4_extra_valid: got pulse at cycle %0d want none", cyc);
      end else begin
        e4 = q4.pop_front();
        check("dut4_byte", {24'h0, byte4}, {24'h0, e4.b});
        check("dut4_cycle", cyc, e4.cyc);
      end
    end
  end

  task automatic wait_ready(input int which);
    int   n;
    logic rdy;
    n   = 0;
    rdy = (which == 1) ? ready1 : ready4;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? ready1 : ready4;
    end
    check("ready_wait", {31'h0, rdy}, 32'h1);
  endtask

  // One-cycle request once ready; expected byte and arrival cycle go to the scoreboard.
  task automatic send(input int which, input logic [7:0] b, input int lat);
    wait_ready(which);
    if (which == 1) begin
      q1.push_back('{b: b, cyc: cyc + lat});
      req1 = 1'b1;
    end else begin
      q4.push_back('{b: b, cyc: cyc + lat});
      req4 = 1'b1;
    end
    @(negedge clk);
    req1 = 1'b0;
    req4 = 1'b0;
  endtask

  task automatic load(input int which, input logic [31:0] k);
    if (which == 1) begin
      key1  = k;
      load1 = 1'b1;
    end else begin
      key4  = k;
      load4 = 1'b1;
    end
    @(negedge clk);
    load1 = 1'b0;
    load4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    key1  = '0;
    key4  = '0;
    load1 = 1'b0;
    load4 = 1'b0;
    req1  = 1'b0;
    req4  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready1", {31'h0, ready1}, 32'h1);
    check("rst_valid1", {31'h0, valid1}, 32'h0);
    check("rst_byte1", {24'h0, byte1}, 32'h0);
    check("rst_ctr1", {16'h0, ctr1}, 32'h0);
    check("rst_ready4", {31'h0, ready4}, 32'h1);
    check("rst_ctr4", {16'h0, ctr4}, 32'h0);

    // Zero key, one round: word is HASH_CONST itself.
    load(1, 32'h0);
    send(1, 8'hB9, 2);
    check("t1_ctr_first", {16'h0, ctr1}, 32'h0);
    send(1, 8'h79, 2);
    send(1, 8'h37, 2);
    send(1, 8'h9E, 2);
    wait_ready(1);
    check("t1_ctr_after_exhaust", {16'h0, ctr1}, 32'h1);

    // Counter wrap: park the counter at FFFF mid-word, the next block must use 0000.
    load(1, K2);
    send(1, wbyte(K2, 16'h0, R1, 0), 2);
    wait_ready(1);
    force dut1.ctr_q = 16'hFFFF;
    @(negedge clk);
    release dut1.ctr_q;
    for (int b = 1; b < 4; b++) send(1, wbyte(K2, 16'h0, R1, b), 2);
    wait_ready(1);
    check("t2_ctr_wrap", {16'h0, ctr1}, 32'h0);
    send(1, wbyte(K2, 16'h0, R1, 0), 2);

    // Request held into H_QUERRIED must not queue a second byte.
    wait_ready(1);
    q1.push_back('{b: wbyte(K2, 16'h0, R1, 1), cyc: cyc + 2});
    req1 = 1'b1;
    repeat (2) @(negedge clk);
    req1 = 1'b0;
    send(1, wbyte(K2, 16'h0, R1, 2), 2);
    send(1, wbyte(K2, 16'h0, R1, 3), 2);
    @(negedge clk);  // H_PULSE_OUT
    @(negedge clk);  // H_EXHAUSTED: this request is dropped
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_ready_idle", {31'h0, ready1}, 32'h1);
    check("t3_dut1_drained", q1.size(), 0);

    // Four rounds, request held for 12 bytes: 3-cycle spacing, +ROUNDS at word edges.
    load(4, K4);
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) begin
        q4.push_back('{b: wbyte(K4, 16'(w), R4, b),
                       cyc: cyc + 1 + R4 + w * (12 + R4) + 3 * b});
      end
    end
    req4 = 1'b1;
    repeat (1 + R4 + 2 * (12 + R4) + 9) @(negedge clk);
    req4 = 1'b0;
    @(negedge clk);  // first regeneration cycle
    check("t4_ctr_three", {16'h0, ctr4}, 32'h3);
    check("t4_dut4_drained", q4.size(), 0);

    // Key load on regeneration cycle 2 with a colliding request.
    @(negedge clk);
    key4  = K5;
    load4 = 1'b1;
    req4  = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    req4  = 1'b0;
    check("t5_ready", {31'h0, ready4}, 32'h1);
    check("t5_ctr", {16'h0, ctr4}, 32'h0);
    check("t5_valid", {31'h0, valid4}, 32'h0);
    repeat (10) @(negedge clk);
    send(4, wbyte(K5, 16'h0, R4, 0), R4 + 1);
    wait_ready(4);

    // Asynchronous reset in the middle of the first mix.
    load(4, K6);
    req4 = 1'b1;
    @(negedge clk);
    req4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_ready4", {31'h0, ready4}, 32'h1);
    check("t6_valid4", {31'h0, valid4}, 32'h0);
    check("t6_byte4", {24'h0, byte4}, 32'h0);
    check("t6_ctr4", {16'h0, ctr4}, 32'h0);
    check("t6_byte1", {24'h0, byte1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // Key register is cleared by reset, so the restart hashes key 0, counter 0.
    send(4, wbyte(32'h0, 16'h0, R4, 0), R4 + 1);
    wait_ready(4);
    check("end_dut1_drained", q1.size(), 0);
    check("end_dut4_drained", q4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
